me_scan_controller: RTL and testbench

- Sequencing controller for the full-search motion estimator: one 16x16 reference block against a 32x32 search window, 16 processing elements (PEs), 256 candidate vectors (-8..+7 in x and y).
- Generates the reference and dual search-memory addresses and the per-PE select/clear controls.
- Issues comparator strobes that tag each finished PE result with its motion vector, then raises process_completed.
- Sits inside top_level as ctrl_u, between the memories, the PE array and the comparator.

---
 rtl/me_pkg.sv | 23 ++
 rtl/me_addr_gen.sv | 34 +++
 rtl/me_scan_controller.sv | 137 +++++++++++++
 tb/tb_me_scan_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared constants, FSM state type and motion-vector code helper for the
// full-search motion-estimator scan controller.
package me_pkg;

   localparam int REF_DIM = 16;
   localparam int WIN_DIM = 32;
   localparam int NUM_PE  = REF_DIM;

   localparam logic [12:0] SCAN_LAST   = 13'd4112;
   localparam logic [12:0] COMP_OFFSET = 13'd257;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Offset-8 code: flipping the top bit maps the two's-complement range -8..+7 onto 0..15.
   function automatic logic [3:0] mv_encode(input logic [3:0] idx);
      return {~idx[3], idx[2:0]};
   endfunction

endpackage

// File: rtl/me_addr_gen.sv
// Count-to-address mapping for the reference and dual search memories.
// Purely combinational; all addresses are forced to zero when en_i is low.
module me_addr_gen
   import me_pkg::*;
(
   input  logic        en_i,
   input  logic [11:0] t_i,
   output logic [7:0]  addr_ref_o,
   output logic [9:0]  addr_s1_o,
   output logic [9:0]  addr_s2_o
);

   logic [7:0] prev_hi;
   logic [4:0] row1;
   logic [4:0] row2;

   always_comb begin
      // Upper bits of (t - 16) mod 4096; the column bits are unchanged by the subtraction.
      prev_hi = t_i[11:4] - 8'd1;
      row1    = {1'b0, t_i[11:8]} + {1'b0, t_i[7:4]};
      row2    = {1'b0, prev_hi[7:4]} + {1'b0, prev_hi[3:0]};

      addr_ref_o = '0;
      addr_s1_o  = '0;
      addr_s2_o  = '0;
      if (en_i) begin
         addr_ref_o = t_i[7:0];
         // row*32 + column; the +16 of the second port lands on bit 4 since column < 16.
         addr_s1_o  = {row1, 1'b0, t_i[3:0]};
         addr_s2_o  = {row2, 1'b1, t_i[3:0]};
      end
   end

endmodule

// File: rtl/me_scan_controller.sv
// Scan sequencer for the 16-PE full-search motion estimator: addresses, PE controls, comparator strobes.
// Addresses are combinational from count; pe_sel/pe_clear lag by one cycle. Optional ME_EARLY_TERM_EN.
module me_scan_controller #(
   parameter int REF_DIM = me_pkg::REF_DIM,
   parameter int WIN_DIM = me_pkg::WIN_DIM
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start_signal,
`ifdef ME_EARLY_TERM_EN
   input  logic                      best_zero,
`endif
   output logic [7:0]                address_ref,
   output logic [9:0]                address_search1,
   output logic [9:0]                address_search2,
   output logic [me_pkg::NUM_PE-1:0] pe_sel,
   output logic [me_pkg::NUM_PE-1:0] pe_clear,
   output logic                      comp_valid,
   output logic [3:0]                comp_pe,
   output logic [3:0]                mv_x,
   output logic [3:0]                mv_y,
   output logic [12:0]               count,
   output logic                      busy,
   output logic                      process_completed
);

   import me_pkg::*;

   generate
      if (WIN_DIM != 2 * REF_DIM || REF_DIM != NUM_PE) begin : g_geom_err
         $error("me_scan_controller: WIN_DIM must be 2*REF_DIM and REF_DIM must be %0d", NUM_PE);
      end
   endgenerate

   state_t            state_q, state_d;
   logic [12:0]       count_q, count_d;
   logic [NUM_PE-1:0] pe_sel_q, pe_sel_d;
   logic [NUM_PE-1:0] pe_clear_q, pe_clear_d;

   logic [11:0] t;
   logic [11:0] u;
   logic        run;
   logic        strobe;
   logic        early_stop;

   assign t   = count_q[11:0];
   assign run = (state_q == RUN);
   assign u   = t - COMP_OFFSET[11:0];

   // Result of PE u[3:0] for vertical vector u[11:8] is ready 257 cycles after its first pixel address.
   assign strobe = run && (count_q >= COMP_OFFSET) && (count_q <= SCAN_LAST) && (u[7:4] == 4'd0);

`ifdef ME_EARLY_TERM_EN
   assign early_stop = strobe && best_zero;
`else
   assign early_stop = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            count_d = '0;
            if (start_signal) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!start_signal) begin
               state_d = IDLE;
               count_d = '0;
            end else if (count_q == SCAN_LAST || early_stop) begin
               state_d = DONE;
            end else begin
               count_d = count_q + 13'd1;
            end
         end
         DONE: begin
            if (!start_signal) begin
               state_d = IDLE;
               count_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   // PE controls are loaded only while the scan continues, so an abort clears them on the next cycle.
   always_comb begin
      pe_sel_d   = '0;
      pe_clear_d = '0;
      if (run && start_signal) begin
         for (int k = 0; k < NUM_PE; k++) begin
            pe_sel_d[k]   = (5'(k) > {1'b0, t[3:0]});
            // (t - k) mod 256 == 0 with k < 16 reduces to t[7:0] == k, which also implies t >= k.
            pe_clear_d[k] = (t[7:0] == 8'(k));
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         pe_sel_q   <= '0;
         pe_clear_q <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         pe_sel_q   <= pe_sel_d;
         pe_clear_q <= pe_clear_d;
      end
   end

   me_addr_gen addr_u (
      .en_i       (run),
      .t_i        (t),
      .addr_ref_o (address_ref),
      .addr_s1_o  (address_search1),
      .addr_s2_o  (address_search2)
   );

   assign pe_sel            = pe_sel_q;
   assign pe_clear          = pe_clear_q;
   assign comp_valid        = strobe;
   assign comp_pe           = strobe ? u[3:0] : 4'd0;
   assign mv_x              = strobe ? mv_encode(u[3:0]) : 4'd0;
   assign mv_y              = strobe ? mv_encode(u[11:8]) : 4'd0;
   assign count             = count_q;
   assign busy              = run;
   assign process_completed = (state_q == DONE);

endmodule

// File: tb/tb_me_scan_controller.sv
// Self-checking bench for me_scan_controller: randomized scan/abort/reset scenarios
// compared every cycle against an arithmetic reference model of the scan schedule.
module tb_me_scan_controller;

   localparam int ST_IDLE = 0;
   localparam int ST_RUN  = 1;
   localparam int ST_DONE = 2;

   logic        clk;
   logic        reset;
   logic        start_signal;
`ifdef ME_EARLY_TERM_EN
   logic        best_zero;
`endif
   logic [7:0]  address_ref;
   logic [9:0]  address_search1;
   logic [9:0]  address_search2;
   logic [15:0] pe_sel;
   logic [15:0] pe_clear;
   logic        comp_valid;
   logic [3:0]  comp_pe;
   logic [3:0]  mv_x;
   logic [3:0]  mv_y;
   logic [12:0] count;
   logic        busy;
   logic        process_completed;

   int n_pass  = 0;
   int n_total = 0;

   me_scan_controller dut (
      .clk               (clk),
      .reset             (reset),
      .start_signal      (start_signal),
`ifdef ME_EARLY_TERM_EN
      .best_zero         (best_zero),
`endif
      .address_ref       (address_ref),
      .address_search1   (address_search1),
      .address_search2   (address_search2),
      .pe_sel            (pe_sel),
      .pe_clear          (pe_clear),
      .comp_valid        (comp_valid),
      .comp_pe           (comp_pe),
      .mv_x              (mv_x),
      .mv_y              (mv_y),
      .count             (count),
      .busy              (busy),
      .process_completed (process_completed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   wire [87:0] obs = {busy, process_completed, count, address_ref, address_search1, address_search2,
                      pe_sel, pe_clear, comp_valid, comp_pe, mv_x, mv_y};

   // Expected outputs for a cycle in state st whose scan counter is cnt.
   function automatic logic [87:0] model(input int st, input int cnt);
      logic [12:0] e_cnt;
      logic [7:0]  e_ref;
      logic [9:0]  e_s1, e_s2;
      logic [15:0] e_sel, e_clr;
      logic        e_cv;
      logic [3:0]  e_pe, e_mx, e_my;
      int t, t2, pt, u;
      e_cnt = '0; e_ref = '0; e_s1 = '0; e_s2 = '0; e_sel = '0; e_clr = '0;
      e_cv = 1'b0; e_pe = '0; e_mx = '0; e_my = '0;
      if (st == ST_DONE) e_cnt = 13'(cnt);
      if (st == ST_RUN) begin
         e_cnt = 13'(cnt);
         t     = cnt % 4096;
         e_ref = 8'(t % 256);
         e_s1  = 10'((t / 256 + (t / 16) % 16) * 32 + t % 16);
         t2    = (t + 4096 - 16) % 4096;
         e_s2  = 10'((t2 / 256 + (t2 / 16) % 16) * 32 + t % 16 + 16);
         if (cnt >= 1) begin
            pt = (cnt - 1) % 4096;
            for (int k = 0; k < 16; k++) begin
               e_sel[k] = (k > pt % 16);
               e_clr[k] = ((pt - k) % 256 == 0) && (pt >= k);
            end
         end
         u = cnt - 257;
         if (u >= 0 && u <= 3855 && u % 256 < 16) begin
            e_cv = 1'b1;
            e_pe = 4'(u % 16);
            e_mx = 4'((u % 16 + 8) % 16);
            e_my = 4'((u / 256 + 8) % 16);
         end
      end
      return {st == ST_RUN, st == ST_DONE, e_cnt, e_ref, e_s1, e_s2, e_sel, e_clr, e_cv, e_pe, e_mx, e_my};
   endfunction

   // PE controls in DONE reflect a don't-care address, so they are not compared there.
   function automatic logic [87:0] mask(input int st);
      return {43'h7FF_FFFF_FFFF, (st == ST_DONE) ? 32'h0 : 32'hFFFF_FFFF, 13'h1FFF};
   endfunction

   task automatic run_full(input string tag);
      int strobes = 0;
      start_signal = 1'b1;
      for (int n = 0; n <= 4112; n++) begin
         @(negedge clk);
         n_total++;
         if ((obs & mask(ST_RUN)) !== (model(ST_RUN, n) & mask(ST_RUN)))
            $display("FAIL %s_run cnt=%0d got=%h exp=%h", tag, n, obs, model(ST_RUN, n));
         else n_pass++;
         if (comp_valid === 1'b1) strobes++;
         if (n == 17) begin
            n_total++;
            if ({address_ref, address_search1, address_search2} !== {8'd17, 10'd33, 10'd17})
               $display("FAIL %s_addr17 got=%0d/%0d/%0d exp=17/33/17", tag, address_ref, address_search1, address_search2);
            else n_pass++;
         end
         if (n == 20) begin
            n_total++;
            if (pe_sel !== 16'hFFF0) $display("FAIL %s_pesel20 got=%h exp=fff0", tag, pe_sel);
            else n_pass++;
         end
         if (n == 257) begin
            n_total++;
            if ({pe_clear, comp_valid, comp_pe, mv_x, mv_y} !== {16'h0001, 1'b1, 4'd0, 4'd8, 4'd8})
               $display("FAIL %s_first_strobe got=%h/%b/%0d/%0d/%0d exp=0001/1/0/8/8", tag, pe_clear, comp_valid, comp_pe, mv_x, mv_y);
            else n_pass++;
         end
         if (n == 272) begin
            n_total++;
            if ({comp_valid, comp_pe, mv_x} !== {1'b1, 4'd15, 4'd7})
               $display("FAIL %s_strobe272 got=%b/%0d/%0d exp=1/15/7", tag, comp_valid, comp_pe, mv_x);
            else n_pass++;
         end
         if (n == 4112) begin
            n_total++;
            if ({comp_valid, comp_pe, mv_x, mv_y} !== {1'b1, 4'd15, 4'd7, 4'd7})
               $display("FAIL %s_last_strobe got=%b/%0d/%0d/%0d exp=1/15/7/7", tag, comp_valid, comp_pe, mv_x, mv_y);
            else n_pass++;
         end
      end
      n_total++;
      if (strobes !== 256) $display("FAIL %s_strobe_count got=%0d exp=256", tag, strobes);
      else n_pass++;
      repeat ($urandom_range(1, 4)) begin
         @(negedge clk);
         n_total++;
         if ((obs & mask(ST_DONE)) !== (model(ST_DONE, 4112) & mask(ST_DONE)))
            $display("FAIL %s_done got=%h exp=%h", tag, obs, model(ST_DONE, 4112));
         else n_pass++;
      end
      start_signal = 1'b0;
      @(negedge clk);
      n_total++;
      if (obs !== model(ST_IDLE, 0)) $display("FAIL %s_idle_after_done got=%h exp=%h", tag, obs, model(ST_IDLE, 0));
      else n_pass++;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start_signal = 1'b0;
      repeat (2) @(negedge clk);
      n_total++;
      if (obs !== model(ST_IDLE, 0)) $display("FAIL reset_hold got=%h exp=%h", obs, model(ST_IDLE, 0));
      else n_pass++;
      start_signal = 1'b1;
      @(negedge clk);
      n_total++;
      if (obs !== model(ST_IDLE, 0)) $display("FAIL reset_dominates got=%h exp=%h", obs, model(ST_IDLE, 0));
      else n_pass++;
      start_signal = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      n_total++;
      if (obs !== model(ST_IDLE, 0)) $display("FAIL reset_release got=%h exp=%h", obs, model(ST_IDLE, 0));
      else n_pass++;
   endtask

   task automatic test_full_scan();
      run_full("full");
   endtask

   task automatic test_abort();
      for (int i = 0; i < 3; i++) begin
         int stop = (i == 0) ? 1000 : int'($urandom_range(1, 3000));
         start_signal = 1'b1;
         for (int n = 0; n <= stop; n++) begin
            @(negedge clk);
            n_total++;
            if ((obs & mask(ST_RUN)) !== (model(ST_RUN, n) & mask(ST_RUN)))
               $display("FAIL abort_run cnt=%0d got=%h exp=%h", n, obs, model(ST_RUN, n));
            else n_pass++;
         end
         start_signal = 1'b0;
         repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            n_total++;
            if (obs !== model(ST_IDLE, 0)) $display("FAIL abort_idle stop=%0d got=%h exp=%h", stop, obs, model(ST_IDLE, 0));
            else n_pass++;
         end
      end
   endtask

   task automatic test_async_reset();
      int stop = 2000 + int'($urandom_range(0, 100));
      start_signal = 1'b1;
      for (int n = 0; n <= stop; n++) begin
         @(negedge clk);
         n_total++;
         if ((obs & mask(ST_RUN)) !== (model(ST_RUN, n) & mask(ST_RUN)))
            $display("FAIL areset_run cnt=%0d got=%h exp=%h", n, obs, model(ST_RUN, n));
         else n_pass++;
      end
      #2 reset = 1'b1;
      #1;
      n_total++;
      if (obs !== model(ST_IDLE, 0)) $display("FAIL areset_immediate got=%h exp=%h", obs, model(ST_IDLE, 0));
      else n_pass++;
      start_signal = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_total++;
      if (obs !== model(ST_IDLE, 0)) $display("FAIL areset_idle got=%h exp=%h", obs, model(ST_IDLE, 0));
      else n_pass++;
      run_full("post_reset");
   endtask

   task automatic test_back_to_back();
      run_full("b2b");
   endtask

`ifdef ME_EARLY_TERM_EN
   task automatic test_early_term();
      int stop = 257 + 256 * int'($urandom_range(0, 14)) + int'($urandom_range(0, 15));
      best_zero = 1'b0;
      start_signal = 1'b1;
      for (int n = 0; n <= stop; n++) begin
         @(negedge clk);
         n_total++;
         if ((obs & mask(ST_RUN)) !== (model(ST_RUN, n) & mask(ST_RUN)))
            $display("FAIL early_run cnt=%0d got=%h exp=%h", n, obs, model(ST_RUN, n));
         else n_pass++;
      end
      best_zero = 1'b1;
      @(negedge clk);
      best_zero = 1'b0;
      repeat (2) begin
         n_total++;
         if ((obs & mask(ST_DONE)) !== (model(ST_DONE, stop) & mask(ST_DONE)))
            $display("FAIL early_done got=%h exp=%h", obs, model(ST_DONE, stop));
         else n_pass++;
         @(negedge clk);
      end
      start_signal = 1'b0;
      @(negedge clk);
      n_total++;
      if (obs !== model(ST_IDLE, 0)) $display("FAIL early_idle got=%h exp=%h", obs, model(ST_IDLE, 0));
      else n_pass++;
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      start_signal = 1'b0;
`ifdef ME_EARLY_TERM_EN
      best_zero = 1'b0;
`endif
      test_reset();
      test_full_scan();
      test_abort();
      test_async_reset();
      test_back_to_back();
`ifdef ME_EARLY_TERM_EN
      test_early_term();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
